// File: rtl/quiz_pkg.sv
// quiz_pkg: state encoding, player/result/choice constants and key validity helper
// Revision 1.0 - initial release
`default_nettype none

package quiz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_OPEN  = 3'd2,
    ST_JUDGE = 3'd3,
    ST_SHOW  = 3'd4
  } round_state_e;

  localparam logic [1:0] PLAYER_NONE = 2'd0;
  localparam logic [1:0] PLAYER_P1   = 2'd1;
  localparam logic [1:0] PLAYER_P2   = 2'd2;

  localparam logic [1:0] RESULT_NONE = 2'd0;
  localparam logic [1:0] RESULT_P1   = 2'd1;
  localparam logic [1:0] RESULT_P2   = 2'd2;

  localparam logic [2:0] CHOICE_NONE = 3'd0;

  // A usable key needs both a choice 1..4 and a player 1..2
  function automatic logic key_valid(input logic [2:0] ans, input logic [1:0] ply);
    return (ans >= 3'd1) && (ans <= 3'd4) &&
           ((ply == PLAYER_P1) || (ply == PLAYER_P2));
  endfunction

endpackage

`default_nettype wire

// File: rtl/remote_press_edge.sv
// remote_press_edge: registers the decoded remote keys and flags a fresh valid press
// Revision 1.0 - initial release
`default_nettype none

module remote_press_edge
  import quiz_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] anssel,
  input  logic [1:0] player,
  output logic       press_vld,
  output logic [2:0] press_ans,
  output logic [1:0] press_ply
);

  logic [4:0] key_q;
  logic [4:0] key_qq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '0;
      key_qq <= '0;
    end else begin
      key_q  <= {anssel, player};
      key_qq <= key_q;
    end
  end

  assign press_ans = key_q[4:2];
  assign press_ply = key_q[1:0];
  // Only an idle -> keyed transition counts, so a held key fires once at most
  assign press_vld = (key_qq == 5'd0) && key_valid(press_ans, press_ply);

endmodule

`default_nettype wire

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: buzzer-round FSM, answer timer and BCD score counters.
// Optional build macro QUIZ_PENALTY_EN: wrong answers also cost one point (floor 0). Revision 1.0
`default_nettype none

module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int unsigned ROUND_TICKS = 10,
  parameter int unsigned SHOW_TICKS  = 3,
  parameter int unsigned MAX_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       clr_scores,
  input  logic [2:0] correct_ans,
  input  logic [2:0] anssel,
  input  logic [1:0] player,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [3:0] time_left,
  output logic [2:0] round_state,
  output logic [1:0] result,
  output logic [1:0] lock_out
);

  localparam logic [3:0] TL_LOAD   = 4'(ROUND_TICKS);
  localparam logic [3:0] SCORE_MAX = 4'(MAX_SCORE);
  localparam logic [3:0] SHOW_LAST = 4'(SHOW_TICKS - 1);

  round_state_e state;
  logic [2:0]   ans_q;
  logic [2:0]   judge_ans;
  logic [1:0]   judge_ply;
  logic [3:0]   show_cnt;

  logic         press_vld;
  logic [2:0]   press_ans;
  logic [1:0]   press_ply;
  logic         press_locked;
  logic [1:0]   lock_wrong;

  remote_press_edge u_press (
    .clk       (clk),
    .rst_n     (rst_n),
    .anssel    (anssel),
    .player    (player),
    .press_vld (press_vld),
    .press_ans (press_ans),
    .press_ply (press_ply)
  );

  assign press_locked = (press_ply == PLAYER_P1) ? lock_out[0] : lock_out[1];
  assign lock_wrong   = lock_out | ((judge_ply == PLAYER_P1) ? 2'b01 : 2'b10);
  assign round_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ans_q     <= CHOICE_NONE;
      judge_ans <= CHOICE_NONE;
      judge_ply <= PLAYER_NONE;
      show_cnt  <= '0;
      score_p1  <= '0;
      score_p2  <= '0;
      time_left <= '0;
      result    <= RESULT_NONE;
      lock_out  <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_scores) begin
            score_p1 <= '0;
            score_p2 <= '0;
          end
          if (start) begin
            ans_q    <= correct_ans;
            result   <= RESULT_NONE;
            lock_out <= 2'b00;
            state    <= ST_ARM;
          end
        end

        ST_ARM: begin
          if (anssel == CHOICE_NONE) begin
            time_left <= TL_LOAD;
            state     <= ST_OPEN;
          end
        end

        // A press outranks a coincident tick; that tick is simply not counted
        ST_OPEN: begin
          if (press_vld && !press_locked) begin
            judge_ans <= press_ans;
            judge_ply <= press_ply;
            state     <= ST_JUDGE;
          end else if (tick) begin
            if (time_left <= 4'd1) begin
              time_left <= '0;
              result    <= RESULT_NONE;
              show_cnt  <= '0;
              state     <= ST_SHOW;
            end else begin
              time_left <= time_left - 4'd1;
            end
          end
        end

        ST_JUDGE: begin
          if (judge_ans == ans_q) begin
            if (judge_ply == PLAYER_P1) begin
              if (score_p1 < SCORE_MAX) score_p1 <= score_p1 + 4'd1;
              result <= RESULT_P1;
            end else begin
              if (score_p2 < SCORE_MAX) score_p2 <= score_p2 + 4'd1;
              result <= RESULT_P2;
            end
            time_left <= '0;
            show_cnt  <= '0;
            state     <= ST_SHOW;
          end else begin
            lock_out <= lock_wrong;
`ifdef QUIZ_PENALTY_EN
            if (judge_ply == PLAYER_P1) begin
              if (score_p1 != 4'd0) score_p1 <= score_p1 - 4'd1;
            end else begin
              if (score_p2 != 4'd0) score_p2 <= score_p2 - 4'd1;
            end
`endif
            if (lock_wrong == 2'b11) begin
              result    <= RESULT_NONE;
              time_left <= '0;
              show_cnt  <= '0;
              state     <= ST_SHOW;
            end else begin
              state <= ST_OPEN;
            end
          end
        end

        ST_SHOW: begin
          if (tick) begin
            if (show_cnt == SHOW_LAST) state <= ST_IDLE;
            else show_cnt <= show_cnt + 4'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
